// File: rtl/mii_rx_frame_parser.sv
// mii_rx_frame_parser: preamble/SFD lock, byte forwarding, length and FCS check with one status record per frame.
// Define STRIP_FCS_EN to hold back the 4 FCS bytes through a delay line instead of forwarding them.
module mii_rx_frame_parser #(
    parameter int MIN_LEN      = 64,
    parameter int MAX_LEN      = 1518,
    parameter int PREAMBLE_MIN = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_frame_en,
    input  logic [7:0]  i_byte_in,
    input  logic        i_byte_valid,
    output logic [7:0]  o_data_out,
    output logic        o_data_valid,
    output logic        o_sof,
    output logic        o_frame_done,
    output logic        o_crc_ok,
    output logic        o_len_err,
    output logic        o_sync_err,
    output logic [10:0] o_frame_len
);
    localparam logic [1:0]  S_IDLE = 2'd0, S_PRE = 2'd1, S_DATA = 2'd2, S_DROP = 2'd3;
    localparam logic [3:0]  PRE_MIN = 4'(PREAMBLE_MIN);
    localparam logic [10:0] LEN_MIN = 11'(MIN_LEN);
    localparam logic [10:0] LEN_OVF = 11'(MAX_LEN + 1);
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    logic [1:0]  r_state;
    logic [3:0]  r_pre_cnt;
    logic [10:0] r_len;
    logic [31:0] r_crc;
    logic        r_ovf;
    logic        r_fen_d;
    logic        r_wait;
`ifdef STRIP_FCS_EN
    logic [31:0] r_dly;
`endif

    logic        w_fall;
    logic        w_acc;
    logic [10:0] w_len_inc;
    logic [1:0]  w_state_n;
    logic [3:0]  w_pre_n;
    logic [10:0] w_len_n;
    logic [31:0] w_crc_n;
    logic        w_ovf_n;
    logic        w_fwd;

    // The byte strobed in the cycle frame_en falls still belongs to the frame.
    // After reset the tail of an abandoned frame is ignored until frame_en goes low.
    assign w_fall    = r_fen_d && !i_frame_en;
    assign w_acc     = i_byte_valid && (i_frame_en || w_fall) && !r_wait;
    assign w_len_inc = (r_len == 11'h7FF) ? r_len : r_len + 11'd1;

    always_comb begin
        w_state_n = r_state;
        w_pre_n   = r_pre_cnt;
        w_len_n   = r_len;
        w_crc_n   = r_crc;
        w_ovf_n   = r_ovf;
        w_fwd     = 1'b0;
        if (w_acc) begin
            case (r_state)
                S_IDLE: begin
                    w_state_n = (i_byte_in == 8'h55) ? S_PRE : S_DROP;
                    w_pre_n   = 4'd1;
                end
                S_PRE: begin
                    w_state_n = (i_byte_in == 8'h55) ? S_PRE :
                                (i_byte_in == 8'hD5 && r_pre_cnt >= PRE_MIN) ? S_DATA : S_DROP;
                    w_pre_n   = (i_byte_in == 8'h55 && r_pre_cnt != 4'hF) ? r_pre_cnt + 4'd1 : r_pre_cnt;
                end
                S_DATA: begin
                    w_crc_n   = crc_byte(r_crc, i_byte_in);
                    w_len_n   = w_len_inc;
                    w_ovf_n   = (w_len_inc == LEN_OVF);
                    w_state_n = w_ovf_n ? S_DROP : S_DATA;
                    w_fwd     = !w_ovf_n;
                end
                default: w_len_n = r_ovf ? w_len_inc : r_len;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_pre_cnt    <= 4'd0;
            r_len        <= 11'd0;
            r_crc        <= CRC_INIT;
            r_ovf        <= 1'b0;
            r_fen_d      <= 1'b0;
            r_wait       <= 1'b1;
            o_data_out   <= 8'd0;
            o_data_valid <= 1'b0;
            o_sof        <= 1'b0;
            o_frame_done <= 1'b0;
            o_crc_ok     <= 1'b0;
            o_len_err    <= 1'b0;
            o_sync_err   <= 1'b0;
            o_frame_len  <= 11'd0;
`ifdef STRIP_FCS_EN
            r_dly        <= 32'd0;
`endif
        end else begin
            r_fen_d      <= i_frame_en;
            r_wait       <= r_wait && i_frame_en;
            r_state      <= w_fall ? S_IDLE : w_state_n;
            r_pre_cnt    <= w_fall ? 4'd0 : w_pre_n;
            r_len        <= w_fall ? 11'd0 : w_len_n;
            r_crc        <= w_fall ? CRC_INIT : w_crc_n;
            r_ovf        <= w_fall ? 1'b0 : w_ovf_n;
            o_data_valid <= 1'b0;
            o_sof        <= 1'b0;
            o_frame_done <= 1'b0;
            if (w_fall && w_state_n != S_IDLE) begin
                o_frame_done <= 1'b1;
                o_crc_ok     <= (w_state_n == S_DATA) && (w_crc_n == CRC_RESIDUE);
                o_len_err    <= (w_len_n < LEN_MIN) || w_ovf_n;
                o_sync_err   <= (w_state_n == S_PRE) || (w_state_n == S_DROP && !w_ovf_n);
                o_frame_len  <= w_len_n;
            end
`ifdef STRIP_FCS_EN
            if (w_fwd) begin
                r_dly <= {r_dly[23:0], i_byte_in};
                if (r_len >= 11'd4) begin
                    o_data_out   <= r_dly[31:24];
                    o_data_valid <= 1'b1;
                    o_sof        <= (r_len == 11'd4);
                end
            end
`else
            if (w_fwd) begin
                o_data_out   <= i_byte_in;
                o_data_valid <= 1'b1;
                o_sof        <= (r_len == 11'd0);
            end
`endif
        end
    end
endmodule

// File: tb/tb_mii_rx_frame_parser.sv
// tb_mii_rx_frame_parser: directed frame vectors plus reset, back-to-back and edge-timing sequences.
module tb_mii_rx_frame_parser;
`ifdef STRIP_FCS_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        fen;
    logic [7:0]  bin;
    logic        bv;
    logic [7:0]  o_data_out;
    logic        o_data_valid;
    logic        o_sof;
    logic        o_frame_done;
    logic        o_crc_ok;
    logic        o_len_err;
    logic        o_sync_err;
    logic [10:0] o_frame_len;

    always #5 clk = ~clk;

    mii_rx_frame_parser dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_frame_en  (fen),
        .i_byte_in   (bin),
        .i_byte_valid(bv),
        .o_data_out  (o_data_out),
        .o_data_valid(o_data_valid),
        .o_sof       (o_sof),
        .o_frame_done(o_frame_done),
        .o_crc_ok    (o_crc_ok),
        .o_len_err   (o_len_err),
        .o_sync_err  (o_sync_err),
        .o_frame_len (o_frame_len)
    );

    typedef struct {
        string      name;
        int         npre;
        logic [7:0] sfd;
        int         plen;
        bit         flip;
        int         dv;
        bit         done;
        bit         crc;
        bit         lerr;
        bit         serr;
        int         flen;
    } vec_t;

    typedef struct packed {
        logic        crc;
        logic        lerr;
        logic        serr;
        logic [10:0] flen;
    } st_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_stray = 0;
    logic [8:0] rx_q[$];
    st_t        done_q[$];
    logic [7:0] tx_q[$];
    vec_t       vecs[10];

    always @(negedge clk) begin
        if (o_data_valid) rx_q.push_back({o_sof, o_data_out});
        else if (o_sof) n_stray++;
        if (o_frame_done) done_q.push_back(st_t'{o_crc_ok, o_len_err, o_sync_err, o_frame_len});
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [31:0] fcs_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int b = 0; b < 8; b++) begin
            fb = r[0] ^ d[b];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB8_8320;
        end
        return r;
    endfunction

    function automatic int adj(input int dv);
        return STRIP ? ((dv > 4) ? dv - 4 : 0) : dv;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    // Strobes one byte every other cycle; cut >= 0 stops after that many post-SFD bytes with frame_en still high.
    task automatic send(input int npre, input logic [7:0] sfd, input int plen, input bit flip,
                        input int cut, input bit fall_last);
        logic [7:0]  seq[$];
        logic [31:0] c;
        int          n;
        tx_q.delete();
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < plen; k++) begin
            tx_q.push_back(8'((k * 37 + 11) % 256));
            c = fcs_step(c, tx_q[k]);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) tx_q.push_back(c[8*k +: 8]);
        if (flip) tx_q[10] = tx_q[10] ^ 8'h08;
        for (int k = 0; k < npre; k++) seq.push_back(8'h55);
        seq.push_back(sfd);
        n = (cut < 0) ? tx_q.size() : cut;
        for (int k = 0; k < n; k++) seq.push_back(tx_q[k]);
        @(negedge clk) fen = 1'b1;
        for (int k = 0; k < seq.size(); k++) begin
            @(negedge clk);
            bv  = 1'b1;
            bin = seq[k];
            if (fall_last && k == seq.size() - 1) fen = 1'b0;
            @(negedge clk) bv = 1'b0;
        end
        if (cut < 0 && !fall_last) @(negedge clk) fen = 1'b0;
    endtask

    task automatic check(input vec_t v);
        int exp_dv;
        int nsof;
        int nerr;
        repeat (4) @(negedge clk);
        exp_dv = adj(v.dv);
        nsof   = 0;
        nerr   = 0;
        foreach (rx_q[i]) begin
            if (rx_q[i][8]) nsof++;
            if (i >= tx_q.size() || rx_q[i][7:0] !== tx_q[i]) nerr++;
        end
        chk({v.name, " data_valid count"}, rx_q.size(), exp_dv);
        chk({v.name, " sof count"}, nsof, (exp_dv > 0) ? 1 : 0);
        if (rx_q.size() > 0) chk({v.name, " sof on first byte"}, int'(rx_q[0][8]), 1);
        chk({v.name, " wrong data bytes"}, nerr, 0);
        chk({v.name, " frame_done count"}, done_q.size(), int'(v.done));
        if (done_q.size() > 0) begin
            chk({v.name, " crc_ok"}, int'(done_q[0].crc), int'(v.crc));
            chk({v.name, " len_err"}, int'(done_q[0].lerr), int'(v.lerr));
            chk({v.name, " sync_err"}, int'(done_q[0].serr), int'(v.serr));
            chk({v.name, " frame_len"}, int'(done_q[0].flen), v.flen);
        end
        rx_q.delete();
        done_q.delete();
    endtask

    initial begin
        vecs[0] = '{"good64",   7, 8'hD5,   60, 1'b0,   64, 1'b1, 1'b1, 1'b0, 1'b0,   64};
        vecs[1] = '{"bitflip",  7, 8'hD5,   60, 1'b1,   64, 1'b1, 1'b0, 1'b0, 1'b0,   64};
        vecs[2] = '{"shortpre", 1, 8'hD5,   60, 1'b0,    0, 1'b1, 1'b0, 1'b1, 1'b1,    0};
        vecs[3] = '{"len20",    7, 8'hD5,   16, 1'b0,   20, 1'b1, 1'b1, 1'b1, 1'b0,   20};
        vecs[4] = '{"pre2_68",  2, 8'hD5,   64, 1'b0,   68, 1'b1, 1'b1, 1'b0, 1'b0,   68};
        vecs[5] = '{"max1518",  7, 8'hD5, 1514, 1'b0, 1518, 1'b1, 1'b1, 1'b0, 1'b0, 1518};
        vecs[6] = '{"over1600", 7, 8'hD5, 1596, 1'b0, 1518, 1'b1, 1'b0, 1'b1, 1'b0, 1600};
        vecs[7] = '{"len63",    7, 8'hD5,   59, 1'b0,   63, 1'b1, 1'b1, 1'b1, 1'b0,   63};
        vecs[8] = '{"nopre",    0, 8'hD5,   60, 1'b0,    0, 1'b1, 1'b0, 1'b1, 1'b1,    0};
        vecs[9] = '{"badsfd",   7, 8'hD4,   60, 1'b0,    0, 1'b1, 1'b0, 1'b1, 1'b1,    0};
        rst = 1'b1;
        fen = 1'b0;
        bv  = 1'b0;
        bin = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset data_valid", int'(o_data_valid), 0);
        chk("reset frame_done", int'(o_frame_done), 0);
        chk("reset status", int'({o_crc_ok, o_len_err, o_sync_err, o_sof}), 0);
        chk("reset frame_len", int'(o_frame_len), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].npre, vecs[i].sfd, vecs[i].plen, vecs[i].flip, -1, 1'b0);
            check(vecs[i]);
        end
        send(7, 8'hD5, 16, 1'b0, -1, 1'b1);
        check('{"fall_with_last", 7, 8'hD5, 16, 1'b0, 20, 1'b1, 1'b1, 1'b1, 1'b0, 20});
        send(7, 8'hD5, 60, 1'b0, 30, 1'b0);
        rst = 1'b1;
        fen = 1'b0;
        @(negedge clk);
        chk("midreset data_valid", int'(o_data_valid), 0);
        chk("midreset data_out", int'(o_data_out), 0);
        chk("midreset crc_ok", int'(o_crc_ok), 0);
        chk("midreset len_err", int'(o_len_err), 0);
        chk("midreset frame_len", int'(o_frame_len), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("midreset bytes before reset", rx_q.size(), adj(30));
        chk("midreset frame_done count", done_q.size(), 0);
        rx_q.delete();
        done_q.delete();
        send(7, 8'hD5, 60, 1'b0, -1, 1'b0);
        check(vecs[0]);
        send(7, 8'hD5, 16, 1'b0, -1, 1'b0);
        send(2, 8'hD5, 16, 1'b0, -1, 1'b0);
        repeat (4) @(negedge clk);
        chk("b2b data_valid count", rx_q.size(), 2 * adj(20));
        chk("b2b frame_done count", done_q.size(), 2);
        if (done_q.size() == 2) begin
            chk("b2b first crc_ok", int'(done_q[0].crc), 1);
            chk("b2b second crc_ok", int'(done_q[1].crc), 1);
            chk("b2b second frame_len", int'(done_q[1].flen), 20);
        end
        rx_q.delete();
        done_q.delete();
        foreach (vecs[0].name[i]) begin
            @(negedge clk);
            bv  = 1'b1;
            bin = (i < 3) ? 8'h55 : (i == 3) ? 8'hD5 : 8'(i);
            @(negedge clk) bv = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("fen low data_valid count", rx_q.size(), 0);
        chk("fen low frame_done count", done_q.size(), 0);
        chk("stray sof", n_stray, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
